// File: rtl/char_lcd_refresh_pkg.sv
// Shared constants, state encodings and the init command table for the
// HD44780 16x1 character LCD refresher.
package char_lcd_refresh_pkg;

    localparam logic [7:0] FUNC_SET_8BIT = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] DDRAM_BASE    = 8'h80;

    localparam int NUM_CHARS     = 16;
    localparam int NUM_INIT_CMDS = 5;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        LOAD,
        ADDR,
        CHAR
    } lcd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD
    } wr_phase_t;

    // Function set is sent twice so the controller latches 8-bit mode reliably.
    function automatic logic [7:0] init_cmd(input logic [2:0] step);
        case (step)
            3'd0, 3'd1: init_cmd = FUNC_SET_8BIT;
            3'd2:       init_cmd = DISP_ON;
            3'd3:       init_cmd = CLEAR;
            default:    init_cmd = ENTRY_INC;
        endcase
    endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One LCD bus write: SETUP (E low, RS/data driven), PULSE (E high), HOLD (E low).
// start/done: start is sampled only while idle; done pulses one cycle at the end of HOLD.
module lcd_write_cycle
    import char_lcd_refresh_pkg::*;
#(
    parameter int SETUP_CNT      = 2,
    parameter int EN_PULSE_CNT   = 16,
    parameter int CMD_WAIT_CNT   = 1350,
    parameter int CLEAR_WAIT_CNT = 45000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data_byte,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    wr_phase_t        phase, phase_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] hold_last;

    // Clear needs the long wait; the latched byte decides, so a later start can't disturb it.
    assign hold_last = (!lcd_rs && (lcd_data == CLEAR)) ? CNT_W'(CLEAR_WAIT_CNT - 1)
                                                        : CNT_W'(CMD_WAIT_CNT - 1);

    always_comb begin
        phase_next = phase;
        cnt_next   = cnt + 1'b1;
        done       = 1'b0;
        case (phase)
            W_IDLE: begin
                cnt_next = '0;
                if (start) phase_next = W_SETUP;
            end
            W_SETUP: begin
                if (cnt == CNT_W'(SETUP_CNT - 1)) begin
                    phase_next = W_PULSE;
                    cnt_next   = '0;
                end
            end
            W_PULSE: begin
                if (cnt == CNT_W'(EN_PULSE_CNT - 1)) begin
                    phase_next = W_HOLD;
                    cnt_next   = '0;
                end
            end
            W_HOLD: begin
                if (cnt == hold_last) begin
                    phase_next = W_IDLE;
                    cnt_next   = '0;
                    done       = 1'b1;
                end
            end
            default: begin
                phase_next = W_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= W_IDLE;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            phase <= phase_next;
            cnt   <= cnt_next;
            lcd_e <= (phase_next == W_PULSE);
            if (phase == W_IDLE && start) begin
                lcd_rs   <= rs;
                lcd_data <= data_byte;
            end
        end
    end

endmodule

// File: rtl/char_lcd_refresh.sv
// Drives a 16x1 HD44780 LCD from a 128-bit text window: power-on init, then a
// full 16-character rewrite whenever the window differs from the last one written.
module char_lcd_refresh
    import char_lcd_refresh_pkg::*;
#(
    parameter int POWERON_WAIT_CNT = 1080000,
    parameter int SETUP_CNT        = 2,
    parameter int EN_PULSE_CNT     = 16,
    parameter int CMD_WAIT_CNT     = 1350,
    parameter int CLEAR_WAIT_CNT   = 45000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] string_data,
    output logic [7:0]   lcd_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic         init_done,
    output logic         busy
);

    localparam int MAX_A    = (POWERON_WAIT_CNT > CLEAR_WAIT_CNT) ? POWERON_WAIT_CNT : CLEAR_WAIT_CNT;
    localparam int MAX_WAIT = (MAX_A > CMD_WAIT_CNT) ? MAX_A : CMD_WAIT_CNT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    lcd_state_t       state, state_next;
    logic [CNT_W-1:0] pwr_cnt, pwr_cnt_next;
    logic [3:0]       idx, idx_next;
    logic [127:0]     snapshot;
    logic             snapshot_load;
    logic             init_done_next;
    logic             wr_start, wr_rs, wr_done;
    logic [7:0]       wr_byte;

    assign lcd_rw = 1'b0;
    assign busy   = (state != IDLE);

    // wr_start is held as a level in transfer states; the write cycle only samples it when idle.
    always_comb begin
        state_next     = state;
        pwr_cnt_next   = pwr_cnt;
        idx_next       = idx;
        init_done_next = init_done;
        snapshot_load  = 1'b0;
        wr_start       = 1'b0;
        wr_rs          = 1'b0;
        wr_byte        = 8'h00;
        case (state)
            PWR_WAIT: begin
                if (pwr_cnt == CNT_W'(POWERON_WAIT_CNT - 1)) begin
                    state_next   = INIT;
                    pwr_cnt_next = '0;
                    idx_next     = '0;
                end else begin
                    pwr_cnt_next = pwr_cnt + 1'b1;
                end
            end
            INIT: begin
                wr_start = 1'b1;
                wr_byte  = init_cmd(idx[2:0]);
                if (wr_done) begin
                    if (idx == 4'(NUM_INIT_CMDS - 1)) begin
                        init_done_next = 1'b1;
                        idx_next       = '0;
                        state_next     = LOAD;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (string_data != snapshot) state_next = LOAD;
            end
            LOAD: begin
                snapshot_load = 1'b1;
                state_next    = ADDR;
            end
            ADDR: begin
                wr_start = 1'b1;
                wr_byte  = DDRAM_BASE;
                if (wr_done) begin
                    idx_next   = '0;
                    state_next = CHAR;
                end
            end
            CHAR: begin
                wr_start = 1'b1;
                wr_rs    = 1'b1;
                wr_byte  = snapshot[8 * (NUM_CHARS - 1 - int'(idx)) +: 8];
                if (wr_done) begin
                    if (idx == 4'(NUM_CHARS - 1)) begin
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PWR_WAIT;
            pwr_cnt   <= '0;
            idx       <= '0;
            init_done <= 1'b0;
            snapshot  <= {NUM_CHARS{8'h20}};
        end else begin
            state     <= state_next;
            pwr_cnt   <= pwr_cnt_next;
            idx       <= idx_next;
            init_done <= init_done_next;
            if (snapshot_load) snapshot <= string_data;
        end
    end

    lcd_write_cycle #(
        .SETUP_CNT      (SETUP_CNT),
        .EN_PULSE_CNT   (EN_PULSE_CNT),
        .CMD_WAIT_CNT   (CMD_WAIT_CNT),
        .CLEAR_WAIT_CNT (CLEAR_WAIT_CNT),
        .CNT_W          (CNT_W)
    ) u_write (
        .clk       (clk),
        .reset     (reset),
        .start     (wr_start),
        .rs        (wr_rs),
        .data_byte (wr_byte),
        .done      (wr_done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data)
    );

endmodule

// File: tb/tb_char_lcd_refresh.sv
// Bench for char_lcd_refresh: bus monitor collects every completed LCD write,
// and the main sequence compares them against the expected command/character stream.
module tb_char_lcd_refresh;

    localparam int PWR   = 50;
    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int CMDW  = 10;
    localparam int CLRW  = 40;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] string_data;
    logic [7:0]   lcd_data;
    logic         lcd_rs, lcd_rw, lcd_e, init_done, busy;

    char_lcd_refresh #(
        .POWERON_WAIT_CNT (PWR),
        .SETUP_CNT        (SETUP),
        .EN_PULSE_CNT     (PULSE),
        .CMD_WAIT_CNT     (CMDW),
        .CLEAR_WAIT_CNT   (CLRW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .string_data (string_data),
        .lcd_data    (lcd_data),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .init_done   (init_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] bus;
        int         rise;
        int         fall;
        int         high;
        int         setup;
        bit         held;
        bit         busy_at_fall;
    } xfer_t;

    xfer_t      obs_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] init_seq [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    int checks = 0;
    int failures = 0;
    int rise_count = 0;
    int init_done_rise = 0;
    bit rw_seen = 1'b0;

    // Bus monitor: one record per completed E pulse; pulses cut short by reset are dropped.
    initial begin : monitor
        logic [8:0] prev_bus = '0;
        logic       prev_e = 1'b0;
        logic       prev_done = 1'b0;
        int         stable = 0;
        xfer_t      cur;
        cur = '{bus: '0, rise: 0, fall: 0, high: 0, setup: 0, held: 1'b0, busy_at_fall: 1'b0};
        forever begin
            @(negedge clk);
            if ({lcd_rs, lcd_data} == prev_bus) stable++;
            else stable = 1;
            if (lcd_rw !== 1'b0) rw_seen = 1'b1;
            if (init_done === 1'b1 && prev_done !== 1'b1) init_done_rise = cyc;
            if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
                rise_count++;
                cur.bus   = {lcd_rs, lcd_data};
                cur.rise  = cyc;
                cur.setup = stable - 1;
                cur.held  = 1'b1;
            end else if (lcd_e === 1'b1) begin
                if ({lcd_rs, lcd_data} != cur.bus) cur.held = 1'b0;
            end else if (prev_e === 1'b1 && reset === 1'b0) begin
                if ({lcd_rs, lcd_data} != cur.bus) cur.held = 1'b0;
                cur.fall         = cyc;
                cur.high         = cyc - cur.rise;
                cur.busy_at_fall = busy;
                obs_q.push_back(cur);
            end
            prev_bus  = {lcd_rs, lcd_data};
            prev_e    = lcd_e;
            prev_done = init_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ge(input string tag, input int obs, input int lo);
        checks++;
        assert (obs >= lo) else begin
            failures++;
            $error("FAIL %s observed=%0d required>=%0d", tag, obs, lo);
        end
    endtask

    task automatic chk_le(input string tag, input int obs, input int hi);
        checks++;
        assert (obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d required<=%0d", tag, obs, hi);
        end
    endtask

    task automatic exp_init();
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, init_seq[i]});
    endtask

    task automatic exp_refresh(input logic [127:0] s);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s[127 - 8 * i -: 8]});
    endtask

    function automatic int hold_for(input logic [8:0] bus);
        return (bus == 9'h001) ? CLRW : CMDW;
    endfunction

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 5 && n < 20000) begin
            @(negedge clk);
            n++;
            quiet = (busy === 1'b0) ? quiet + 1 : 0;
        end
        chk_le({tag, " idle timeout"}, n, 19999);
    endtask

    task automatic wait_rises(input int target, input string tag);
        int n = 0;
        while (rise_count < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk_le({tag, " E rise timeout"}, n, 19999);
    endtask

    task automatic check_run(input string tag);
        chk({tag, " write count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s w%0d rs/byte", tag, i), 32'(obs_q[i].bus), 32'(exp_q[i]));
            chk($sformatf("%s w%0d E width", tag, i), obs_q[i].high, PULSE);
            chk_ge($sformatf("%s w%0d setup", tag, i), obs_q[i].setup, SETUP);
            chk($sformatf("%s w%0d held", tag, i), 32'(obs_q[i].held), 1);
            if (i + 1 < obs_q.size())
                chk_ge($sformatf("%s w%0d gap", tag, i), obs_q[i + 1].rise - obs_q[i].fall,
                       hold_for(exp_q[i]) + SETUP);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic new_string(output logic [127:0] s);
        s = {$urandom, $urandom, $urandom, $urandom};
        if (s == string_data) s[0] = ~s[0];
    endtask

    initial begin
        int           rel;
        int           base;
        logic [127:0] s1, s2;

        string_data = {16{8'h20}};
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset lcd_data", lcd_data, 0);
        chk("reset lcd_rs", lcd_rs, 0);
        chk("reset lcd_rw", lcd_rw, 0);
        chk("reset lcd_e", lcd_e, 0);
        chk("reset init_done", init_done, 0);
        chk("reset busy", busy, 1);

        reset = 1'b0;
        rel = cyc;
        exp_init();
        exp_refresh(string_data);
        wait_idle("init");
        if (obs_q.size() > 0) chk_ge("first E rise delay", obs_q[0].rise - rel, PWR + SETUP);
        if (obs_q.size() >= 22) begin
            chk_ge("init_done after 0x06 hold", init_done_rise - obs_q[4].fall, CMDW);
            chk("busy during last char", 32'(obs_q[21].busy_at_fall), 1);
        end
        chk("init_done set", init_done, 1);
        chk("busy low in idle", busy, 0);
        check_run("init");

        base = rise_count;
        repeat (200) @(negedge clk);
        chk("static input E pulses", rise_count, base);

        string_data = "HELLO WORLD     ";
        exp_refresh(string_data);
        wait_idle("hello");
        check_run("hello");

        new_string(s1);
        string_data = s1;
        base = rise_count;
        wait_rises(base + 7, "mid change");
        string_data = "ABCDEFGHIJKLMNOP";
        exp_refresh(s1);
        exp_refresh(string_data);
        wait_idle("mid change");
        if (obs_q.size() >= 18)
            chk_le("second refresh start", obs_q[17].rise - obs_q[16].fall, CMDW + SETUP + 4);
        check_run("mid change");

        for (int r = 0; r < 4; r++) begin
            new_string(s1);
            string_data = s1;
            exp_refresh(s1);
            if ($urandom_range(0, 1) == 1) begin
                base = rise_count;
                wait_rises(base + 2 + $urandom_range(0, 15), "random change");
                new_string(s2);
                string_data = s2;
                exp_refresh(s2);
            end
            wait_idle("random");
            check_run($sformatf("random%0d", r));
        end

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = rise_count;
        wait_rises(base + 3, "third init cmd");
        @(negedge clk);
        chk("E high before reset", lcd_e, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset lcd_e", lcd_e, 0);
        chk("mid reset init_done", init_done, 0);
        chk("mid reset busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        rel = cyc;
        exp_init();
        exp_refresh(string_data);
        wait_idle("restart");
        if (obs_q.size() > 0) chk_ge("restart first E rise delay", obs_q[0].rise - rel, PWR + SETUP);
        check_run("restart");

        chk("lcd_rw never high", 32'(rw_seen), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_lcd_refresh.md
Name: char_lcd_refresh

Overview:
- Downstream consumer of the 16-character scroller output.
- Takes the 128-bit `string_data` window and drives a 16x1 HD44780-compatible character LCD over an 8-bit write-only parallel bus.
- Performs power-on initialisation, then rewrites all 16 characters whenever the window contents change.
- Sits between the UI text path and the LCD pins.

Parameters:
- POWERON_WAIT_CNT, 1080000, cycles to wait after reset before the first command (40 ms at 27 MHz).
- SETUP_CNT, 2, cycles RS/data are held stable before E rises.
- EN_PULSE_CNT, 16, cycles E is held high.
- CMD_WAIT_CNT, 1350, cycles after E falls before the next transfer (50 us).
- CLEAR_WAIT_CNT, 45000, post-transfer wait after the clear command 0x01 (1.67 ms).

Ports:
- clk  input  1  system clock (27 MHz)
- reset  input  1  synchronous, active-high reset
- string_data  input  128  16 ASCII chars; char 0 (leftmost) = [127:120], char 15 = [7:0]
- lcd_data  output  8  LCD DB7..DB0
- lcd_rs  output  1  0 = command, 1 = character data
- lcd_rw  output  1  tied 0 (write only)
- lcd_e  output  1  LCD enable strobe
- init_done  output  1  high once the init sequence has completed
- busy  output  1  high during init or a refresh

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-high.
- Reset values: lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_e=0, init_done=0, busy=1. All counters clear; FSM enters PWR_WAIT.
- Reset mid-transfer: E drops on the next edge and the full init sequence restarts.
- Transfer cycle (write sub-module), 3 phases:
  - SETUP: rs/data driven, E=0, for SETUP_CNT cycles.
  - PULSE: E=1 for EN_PULSE_CNT cycles.
  - HOLD: E=0 with rs/data unchanged, for CMD_WAIT_CNT cycles, or CLEAR_WAIT_CNT when the byte is 0x01 with rs=0.
  - `done` pulses for 1 cycle at the end of HOLD.
  - Total transfer = SETUP_CNT + EN_PULSE_CNT + wait cycles. `start` is ignored while a transfer is active.
- Main FSM states:
  - PWR_WAIT: count POWERON_WAIT_CNT cycles -> INIT.
  - INIT: issue commands 0x38, 0x38, 0x0C, 0x01, 0x06 in order, one transfer each, rs=0. After the last `done`: set init_done=1 -> LOAD.
  - IDLE: busy=0. If string_data != snapshot -> LOAD.
  - LOAD: capture string_data into snapshot (1 cycle); busy=1 -> ADDR.
  - ADDR: transfer 0x80 (DDRAM address 0), rs=0 -> CHAR.
  - CHAR: idx counts 0..15. Each step transfers snapshot char idx with rs=1. After idx=15 `done` -> IDLE.
- First refresh: the snapshot is not compared after init. The first refresh always occurs, so the LCD shows the reset blank (0x20 x16) even if the input never changes.
- Input changes during a refresh: they do not alter the bytes being written, because only the snapshot is used. On return to IDLE the compare runs again; a difference triggers LOAD on the next cycle.
- Counter width: counters sized to hold max(POWERON_WAIT_CNT, CLEAR_WAIT_CNT) (21 bits at defaults).
- Full-refresh latency at defaults: about 17 x 1368 cycles (about 0.86 ms). This is faster than the 9 M-cycle scroll step, so no scroll update is lost.
- Character filtering: none. Bytes are passed through unchanged.

Decomposition:
- Shared package holds:
  - HD44780 command constants: FUNC_SET_8BIT=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06, DDRAM_BASE=0x80.
  - NUM_CHARS=16.
  - FSM state encoding.
- One sub-module, `lcd_write_cycle`:
  - Inputs: start, rs, byte.
  - Outputs: done, lcd_e, lcd_rs, lcd_data.
  - Owns the SETUP/PULSE/HOLD counter and the clear-wait selection.
- Top level holds the init/refresh FSM and the snapshot.

Test Plan:
- Bench uses POWERON_WAIT_CNT=50, SETUP_CNT=2, EN_PULSE_CNT=4, CMD_WAIT_CNT=10, CLEAR_WAIT_CNT=40.
- Reset then idle: first E rise no earlier than 52 cycles after reset deasserts. E-fall bytes are 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0. Gap after 0x01 is at least 40 cycles. init_done rises after the 0x06 done.
- Init then first refresh with string_data held at 0x20 x16: writes 0x80 (rs=0) then sixteen 0x20 (rs=1). busy falls after the 16th write. No further E pulses while the input is static.
- In IDLE, set string_data = "HELLO WORLD     ": one refresh writes 0x80, then 'H' (0x48) first through ' ' (0x20) last, in order.
- Change string_data to "ABCDEFGHIJKLMNOP" during char idx 5 of a refresh: the current refresh completes with the old bytes. A second refresh immediately follows with 'A' (0x41) .. 'P' (0x50).
- Assert reset while E=1 during the 3rd init command: next cycle lcd_e=0, init_done=0, busy=1. The full sequence restarts from PWR_WAIT.
- Every transfer: rs/data stable from at least 2 cycles before E rises until the next transfer's SETUP phase. E high exactly 4 cycles. lcd_rw=0 throughout.
